// File: rtl/debug_bridge.sv
// debug_bridge
// Turns one debug-controller read request into a single access toward the core. The access goes
// to data memory, the register file or instruction memory. It waits for the target to accept, or
// aborts after TIMEOUT cycles. Completion is signalled with a one-cycle doneSending pulse. The
// bridge then waits for tx_flag to drop before it accepts another request.
//
// Ports
//   CLK             system clock, rising edge
//   RST             synchronous active-high reset
//   tx_flag         request level from the debug controller
//   mode[2:0]       001 dmem read, 010 regfile read, 101 imem read; others unsupported
//   address_bridged byte address (memories) or register index (register file)
//   data_internal   read result, held between transactions
//   doneSending     one-cycle completion pulse
//   bridge_err      sticky error: timeout or unsupported mode
//   mem_req         access request level, held until mem_ack or timeout
//   mem_sel[1:0]    00 dmem, 01 regfile, 10 imem
//   mem_addr        access address
//   mem_ack         target accepted; mem_rdata valid in the same cycle
//   mem_rdata       target read data
module debug_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tx_flag,
  input  logic [2:0]  mode,
  input  logic [31:0] address_bridged,
  output logic [31:0] data_internal,
  output logic        doneSending,
  output logic        bridge_err,
  output logic        mem_req,
  output logic [1:0]  mem_sel,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE    = 3'd1;
  localparam logic [2:0] WAIT_ACK = 3'd2;
  localparam logic [2:0] DONE     = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;

  // The counter only has to reach TIMEOUT-1: it runs 0..TIMEOUT-1 while mem_req is high.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  localparam logic [2:0] ModeDmem = 3'b001;
  localparam logic [2:0] ModeReg  = 3'b010;
  localparam logic [2:0] ModeImem = 3'b101;

  logic [2:0]    state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          req_q, req_d;
  logic [1:0]    sel_q, sel_d;
  logic [31:0]   maddr_q, maddr_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    req_d   = req_q;
    sel_d   = sel_q;
    maddr_d = maddr_q;

    case (state_q)
      IDLE: begin
        if (tx_flag) begin
          mode_d  = mode;
          addr_d  = address_bridged;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        case (mode_q)
          ModeDmem, ModeImem: begin
            sel_d   = (mode_q == ModeDmem) ? 2'b00 : 2'b10;
            maddr_d = {addr_q[31:2], 2'b00};
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end
          ModeReg: begin
            if (addr_q[4:0] == 5'd0) begin
              // x0 reads as zero without a core access; counts as a successful transaction
              data_d  = 32'd0;
              err_d   = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              sel_d   = 2'b01;
              maddr_d = {27'd0, addr_q[4:0]};
              req_d   = 1'b1;
              cnt_d   = '0;
              state_d = WAIT_ACK;
            end
          end
          default: begin
            data_d  = ERR_WORD;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        endcase
      end

      WAIT_ACK: begin
        // mem_ack is tested first so an ack on the final counted cycle still wins
        if (mem_ack) begin
          data_d  = mem_rdata;
          err_d   = 1'b0;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CntLast) begin
          data_d  = ERR_WORD;
          err_d   = 1'b1;
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = RELEASE;
      end

      RELEASE: begin
        // A held tx_flag parks here, so one request level yields exactly one transaction
        if (!tx_flag) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mode_q  <= 3'd0;
      addr_q  <= 32'd0;
      cnt_q   <= '0;
      data_q  <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      sel_q   <= 2'b00;
      maddr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      maddr_q <= maddr_d;
    end
  end

  assign data_internal = data_q;
  assign doneSending   = done_q;
  assign bridge_err    = err_q;
  assign mem_req       = req_q;
  assign mem_sel       = sel_q;
  assign mem_addr      = maddr_q;

endmodule

// File: tb/tb_debug_bridge.sv
// Scoreboard bench for debug_bridge. The stimulus side derives each transaction's outcome from the
// access rules and queues it. The responder plays the core and acks after a chosen delay. The
// monitor checks requests, completions and held outputs as they appear.
module tb_debug_bridge;

  localparam int unsigned TIMEOUT  = 255;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        tx_flag = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [31:0] address_bridged = 32'd0;
  logic [31:0] data_internal;
  logic        doneSending;
  logic        bridge_err;
  logic        mem_req;
  logic [1:0]  mem_sel;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  debug_bridge #(
    .TIMEOUT  (TIMEOUT),
    .ERR_WORD (ERR_WORD)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .tx_flag         (tx_flag),
    .mode            (mode),
    .address_bridged (address_bridged),
    .data_internal   (data_internal),
    .doneSending     (doneSending),
    .bridge_err      (bridge_err),
    .mem_req         (mem_req),
    .mem_sel         (mem_sel),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    int          len;
  } req_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
    logic        rst_ack;
  } ack_t;

  resp_t exp_q[$];
  req_t  req_q[$];
  ack_t  ack_q[$];

  int checks = 0;
  int failures = 0;
  int wait_expired = 0;
  bit tb_end = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One read from the debug controller. Delay d is the number of request cycles without ack.
  task automatic run_txn(input logic [2:0] m, input logic [31:0] a, input int d,
                         input bit early_drop, input int hold);
    logic [31:0] rd;
    resp_t e;
    req_t  q;
    ack_t  k;
    int    n;
    rd = $urandom();
    if (!(m == 3'b001 || m == 3'b010 || m == 3'b101)) begin
      e = '{ERR_WORD, 1'b1, 2};
    end else if (m == 3'b010 && (a % 32) == 0) begin
      e = '{32'd0, 1'b0, 2};
    end else begin
      q.sel  = (m == 3'b001) ? 2'd0 : (m == 3'b010) ? 2'd1 : 2'd2;
      q.addr = (m == 3'b010) ? (a % 32) : (a / 4) * 4;
      if (d < int'(TIMEOUT)) begin
        e     = '{rd, 1'b0, d + 3};
        q.len = d + 1;
      end else begin
        e     = '{ERR_WORD, 1'b1, int'(TIMEOUT) + 2};
        q.len = int'(TIMEOUT);
      end
      k = '{d, rd, 1'b0};
      req_q.push_back(q);
      ack_q.push_back(k);
    end
    exp_q.push_back(e);

    @(posedge CLK); #1;
    tx_flag = 1'b1;
    mode = m;
    address_bridged = a;
    if (early_drop) begin
      @(posedge CLK); #1;
      tx_flag = 1'b0;
    end
    n = 0;
    while (!doneSending && n < 400) begin
      @(posedge CLK); #1;
      // Inputs after the latch must not matter
      mode = 3'($urandom_range(0, 7));
      address_bridged = $urandom();
      n++;
    end
    if (n >= 400) wait_expired++;
    repeat (hold) begin
      @(posedge CLK); #1;
    end
    tx_flag = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
  endtask

  // Reset lands while the request is outstanding; the core then acks one cycle later.
  task automatic reset_in_wait();
    ack_t k;
    req_t q;
    int   n;
    k = '{100000, 32'hA5A55A5A, 1'b1};
    q = '{2'd0, 32'h0000_0040, 0};
    ack_q.push_back(k);
    req_q.push_back(q);
    @(posedge CLK); #1;
    tx_flag = 1'b1;
    mode = 3'b001;
    address_bridged = 32'h0000_0043;
    n = 0;
    while (!mem_req && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 10) wait_expired++;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    tx_flag = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin : driver
    logic [2:0]  m;
    logic [31:0] a;
    int          d;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    run_txn(3'b001, 32'h0000_0106, 3, 1'b0, 1);       // dmem read, ack after 3 cycles
    run_txn(3'b010, 32'h0000_0000, 0, 1'b0, 0);       // x0 read, no access
    run_txn(3'b001, 32'h0000_2000, 100000, 1'b0, 0);  // never acked -> timeout
    run_txn(3'b011, 32'h0000_0010, 0, 1'b0, 0);       // unsupported mode
    run_txn(3'b101, 32'h0000_0207, 2, 1'b0, 0);       // success clears the error
    run_txn(3'b101, 32'h0000_1003, 254, 1'b0, 0);     // ack on the timeout cycle wins
    run_txn(3'b001, 32'h0000_0044, 255, 1'b0, 0);     // one cycle too late -> timeout
    run_txn(3'b010, 32'hFFFF_FFE7, 1, 1'b0, 20);      // tx_flag held 20 cycles after done
    run_txn(3'b001, 32'h0000_0088, 4, 1'b1, 0);       // tx_flag dropped during the access
    reset_in_wait();
    run_txn(3'b010, 32'h0000_0005, 0, 1'b0, 0);
    for (int i = 0; i < 150; i++) begin
      m = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 2))
          0:       m = 3'b001;
          1:       m = 3'b010;
          default: m = 3'b101;
        endcase
      end
      a = $urandom();
      if (m == 3'b010 && $urandom_range(0, 4) == 0) a = a & 32'hFFFF_FFE0;
      d = ($urandom_range(0, 29) == 0) ? int'($urandom_range(250, 260))
                                       : int'($urandom_range(0, 8));
      run_txn(m, a, d, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)));
    end
    repeat (5) begin
      @(posedge CLK); #1;
    end
    tb_end = 1'b1;
  end

  initial begin : responder
    ack_t cur;
    bit   active;
    bit   pend;
    int   n;
    active = 1'b0;
    pend = 1'b0;
    n = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge CLK); #2;
      mem_ack = 1'b0;
      if (pend) begin
        mem_ack = 1'b1;
        mem_rdata = cur.rdata;
        pend = 1'b0;
      end
      if (RST) begin
        if (active && cur.rst_ack) pend = 1'b1;
        active = 1'b0;
      end else begin
        if (!active && mem_req && ack_q.size() > 0) begin
          cur = ack_q.pop_front();
          active = 1'b1;
          n = 0;
        end
        if (active) begin
          if (!mem_req) begin
            active = 1'b0;
          end else begin
            if (n == cur.delay) begin
              mem_ack = 1'b1;
              mem_rdata = cur.rdata;
            end
            n++;
          end
        end
      end
    end
  end

  initial begin : monitor
    int          cyc;
    int          tx_start;
    int          n;
    bit          prev_tx;
    bit          in_req;
    bit          have_cur;
    bit          post_rst;
    req_t        cur;
    resp_t       e;
    logic [31:0] last_data;
    logic        last_err;
    cyc = 0;
    tx_start = 0;
    n = 0;
    prev_tx = 1'b0;
    in_req = 1'b0;
    have_cur = 1'b0;
    post_rst = 1'b0;
    last_data = 32'd0;
    last_err = 1'b0;
    while (!tb_end) begin
      @(negedge CLK);
      cyc++;
      if (tx_flag && !prev_tx) tx_start = cyc;
      prev_tx = tx_flag;
      if (RST) begin
        in_req = 1'b0;
        last_data = 32'd0;
        last_err = 1'b0;
        post_rst = 1'b1;
      end else begin
        if (post_rst) begin
          check("reset_outputs", {mem_req, doneSending, mem_sel, mem_addr},
                {1'b0, 1'b0, 2'b00, 32'd0});
          post_rst = 1'b0;
        end
        if (mem_req && !in_req) begin
          in_req = 1'b1;
          n = 0;
          check("req_expected", 64'(req_q.size() > 0), 64'd1);
          have_cur = (req_q.size() > 0);
          if (have_cur) begin
            cur = req_q.pop_front();
            check("mem_sel", 64'(mem_sel), 64'(cur.sel));
            check("mem_addr", 64'(mem_addr), 64'(cur.addr));
          end
        end
        if (in_req) begin
          if (mem_req) begin
            n++;
          end else begin
            in_req = 1'b0;
            if (have_cur) check("req_len", 64'(n), 64'(cur.len));
          end
        end
        if (doneSending) begin
          check("done_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data_internal", 64'(data_internal), 64'(e.data));
            check("bridge_err", 64'(bridge_err), 64'(e.err));
            check("latency", 64'(cyc - tx_start), 64'(e.lat));
            last_data = e.data;
            last_err = e.err;
          end
        end else if (!mem_req) begin
          check("hold", {31'd0, bridge_err, data_internal}, {31'd0, last_err, last_data});
        end
      end
    end
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("req_q_drained", 64'(req_q.size()), 64'd0);
    check("wait_bound", 64'(wait_expired), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_bridge.md
DEBUG_BRIDGE -- requirements
Module: debug_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for mem_ack before aborting.
REQ-002 SHALL have parameter ERR_WORD, default 32'hDEADBEEF, meaning the data returned on timeout or unsupported mode.
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 tx_flag  input  1  transaction request from the debug controller; level, held until doneSending seen.
REQ-006 mode  input  3  access type: 001 data-memory read, 010 register-file read, 101 instruction-memory read; others unsupported.
REQ-007 address_bridged  input  32  target address (byte address for memories, index for the register file).
REQ-008 data_internal  output  32  read result returned to the debug controller.
REQ-009 doneSending  output  1  one-cycle completion pulse.
REQ-010 bridge_err  output  1  sticky error flag (timeout or unsupported mode).
REQ-011 mem_req  output  1  access request toward the core; level until mem_ack.
REQ-012 mem_sel  output  2  target: 00 data mem, 01 register file, 10 instruction mem.
REQ-013 mem_addr  output  32  access address.
REQ-014 mem_ack  input  1  target accepts; mem_rdata valid in the same cycle.
REQ-015 mem_rdata  input  32  target read data.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, DONE, RELEASE.
REQ-017 IDLE: on tx_flag=1, SHALL latch mode and address_bridged, then go to ISSUE; mode and address changes after the latch SHALL be ignored until RELEASE exits.
REQ-018 ISSUE, supported mode: SHALL assert mem_req with decoded mem_sel, clear the timeout counter, and go to WAIT_ACK.
REQ-019 Memory modes (001, 101): mem_addr SHALL be the latched address with bits [1:0] forced to 00.
REQ-020 Register mode (010): mem_addr SHALL be {27'b0, addr[4:0]}.
REQ-021 Register mode with addr[4:0]=0: no request SHALL be issued; data_internal SHALL be 0; go directly to DONE.
REQ-022 Unsupported mode in ISSUE: no request SHALL be issued; data_internal SHALL be ERR_WORD; bridge_err SHALL be set; go to DONE.
REQ-023 WAIT_ACK: mem_req SHALL stay 1; the counter SHALL increment each cycle without mem_ack.
REQ-024 On mem_ack=1, data_internal SHALL capture mem_rdata, mem_req SHALL drop next cycle, and the FSM SHALL go to DONE.
REQ-025 If the counter reaches TIMEOUT without mem_ack, data_internal SHALL be ERR_WORD, bridge_err SHALL be set, mem_req SHALL drop, and the FSM SHALL go to DONE.
REQ-026 If mem_ack arrives in the same cycle as the timeout, mem_ack SHALL win.
REQ-027 DONE: doneSending SHALL be 1 for exactly one cycle, then the FSM SHALL go to RELEASE.
REQ-028 RELEASE: the FSM SHALL remain until tx_flag=0, then return to IDLE; a tx_flag held high SHALL never start a second transaction.
REQ-029 Dropping tx_flag in ISSUE or WAIT_ACK SHALL NOT abort the access; it SHALL complete, pulse doneSending, and pass through RELEASE.
REQ-030 data_internal SHALL hold its value between transactions.
REQ-031 bridge_err SHALL clear only on RST or when a later transaction completes successfully.
REQ-032 Access latency: doneSending SHALL assert 2 cycles after the cycle mem_ack is sampled, counting from the ISSUE entry.

Reset
REQ-033 On RST=1 at a clock edge, the FSM SHALL return to IDLE and SHALL clear mem_req, doneSending, bridge_err, the counter, mem_sel, mem_addr and data_internal.
REQ-034 RST mid-transaction SHALL drop mem_req on the next edge; a mem_ack arriving during or after reset SHALL be ignored.

Verification
REQ-035 mode=001, addr=0x00000106, tx_flag=1, mem_ack after 3 cycles with rdata 0x12345678 -> mem_addr=0x00000104, mem_sel=00, data_internal=0x12345678, one doneSending pulse, bridge_err=0.
REQ-036 mode=010, addr=0x0 -> no mem_req, data_internal=0, doneSending 2 cycles after tx_flag is sampled.
REQ-037 mode=001, mem_ack never asserted, TIMEOUT=255 -> mem_req high 255 cycles, then data_internal=0xDEADBEEF, bridge_err=1, one doneSending pulse.
REQ-038 mode=011 with tx_flag=1 -> no mem_req, data_internal=0xDEADBEEF, bridge_err=1; a following successful mode=101 read clears bridge_err.
REQ-039 tx_flag held high for 20 cycles after doneSending -> exactly one transaction; a new access starts only after a tx_flag 0->1 cycle.
REQ-040 RST asserted in WAIT_ACK, mem_ack asserted the next cycle -> IDLE, mem_req=0, data_internal=0, no doneSending pulse.
